// File: rtl/tx_fault_resp_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// tx_fault_resp_ctrl_pkg
// Shared definitions for the transmit fault-response controller:
//   - controller state encodings (visible on the debug `state` port)
//   - link_fault status encodings
//   - classified fault type and helpers that map the raw status to a type
//     and a fault type to the state that services it
//   - default debounce / drain-timeout lengths
// ---------------------------------------------------------------------------
package tx_fault_resp_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_NORMAL   = 3'd0,
    ST_DRAIN    = 3'd1,
    ST_F_LOCAL  = 3'd2,
    ST_F_REMOTE = 3'd3,
    ST_RECOVER  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    FT_NONE = 2'd0,
    FT_LOC  = 2'd1,
    FT_REM  = 2'd2
  } fault_e;

  localparam logic [1:0] LF_OK     = 2'b00;
  localparam logic [1:0] LF_REMOTE = 2'b01;
  localparam logic [1:0] LF_LOCAL  = 2'b10;

  localparam int CLEAR_CYCLES_DEFAULT = 128;
  localparam int DRAIN_MAX_DEFAULT    = 1024;

  // Local fault dominates: 11 is handled as a local fault.
  function automatic fault_e classify_fault(input logic [1:0] eff);
    if (eff[1]) return FT_LOC;
    if (eff[0]) return FT_REM;
    return FT_NONE;
  endfunction

  // State that services a given fault type; no fault means normal traffic.
  function automatic state_e fault_target(input fault_e ftype);
    case (ftype)
      FT_LOC:  return ST_F_LOCAL;
      FT_REM:  return ST_F_REMOTE;
      default: return ST_NORMAL;
    endcase
  endfunction

endpackage

// File: rtl/tx_fault_resp_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// tx_fault_resp_ctrl_sat_counter
// Saturating event counter used for the fault-episode statistics.
//   clk    : clock
//   rst_n  : asynchronous reset, active-low
//   inc    : count one event this cycle (ignored once at all-ones)
//   clr    : synchronous clear, wins over inc in the same cycle
//   count  : current count
// ---------------------------------------------------------------------------
module tx_fault_resp_ctrl_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/tx_fault_resp_ctrl.sv
// ---------------------------------------------------------------------------
// tx_fault_resp_ctrl
// Transmit-side reaction to the receive link-fault status. Grants MAC frames
// while the link is healthy, lets an in-flight frame finish (bounded by a
// drain timeout) when a fault appears, steers the TX datapath to Idle or
// Remote Fault ordered sets, and debounces fault clearing before traffic
// resumes. Counts local / remote fault episodes with saturating counters.
//
// Ports:
//   rxclk_2x      : single clock
//   reset         : asynchronous reset, active-low
//   link_fault    : 00 OK, 10 local, 01 remote, 11 local
//   fault_resp_en : 0 forces the fault status to OK
//   tx_req        : MAC frame request (level, held until granted)
//   tx_done       : pulse on the last column of the granted frame
//   cnt_clr       : synchronous clear of both statistics counters
//   tx_grant      : one-cycle pulse, frame may start
//   tx_abort      : one-cycle pulse, in-flight frame killed on drain timeout
//   send_idle     : datapath sends Idle
//   send_rf       : datapath sends Remote Fault ordered sets
//   link_ok       : high only while in NORMAL
//   state         : current state encoding (debug)
//   local_cnt     : local-fault episodes
//   remote_cnt    : remote-fault episodes
// ---------------------------------------------------------------------------
module tx_fault_resp_ctrl
  import tx_fault_resp_ctrl_pkg::*;
#(
  parameter int CLEAR_CYCLES = CLEAR_CYCLES_DEFAULT,
  parameter int DRAIN_MAX    = DRAIN_MAX_DEFAULT,
  parameter int CNT_W        = 16
) (
  input  logic             rxclk_2x,
  input  logic             reset,
  input  logic [1:0]       link_fault,
  input  logic             fault_resp_en,
  input  logic             tx_req,
  input  logic             tx_done,
  input  logic             cnt_clr,
  output logic             tx_grant,
  output logic             tx_abort,
  output logic             send_idle,
  output logic             send_rf,
  output logic             link_ok,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] local_cnt,
  output logic [CNT_W-1:0] remote_cnt
);

  localparam int DRAIN_W = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
  localparam int CLEAR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_MAX - 1);
  localparam logic [CLEAR_W-1:0] CLEAR_LAST = CLEAR_W'(CLEAR_CYCLES - 1);

  state_e             st;
  state_e             nxt;
  logic               busy;
  logic               busy_nxt;
  logic               grant_nxt;
  logic               abort_nxt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [CLEAR_W-1:0] clear_cnt;
  logic [1:0]         eff;
  fault_e             ftype;
  logic               local_inc;
  logic               remote_inc;

  assign eff   = fault_resp_en ? link_fault : LF_OK;
  assign ftype = classify_fault(eff);
  assign state = st;

  // Next-state and pulse decisions.
  always_comb begin
    nxt       = st;
    busy_nxt  = busy;
    grant_nxt = 1'b0;
    abort_nxt = 1'b0;
    case (st)
      ST_NORMAL: begin
        if (ftype != FT_NONE) begin
          // A frame that ends in this very cycle needs no draining.
          if (busy && !tx_done) begin
            nxt = ST_DRAIN;
          end else begin
            nxt      = fault_target(ftype);
            busy_nxt = 1'b0;
          end
        end else if (tx_req && !busy) begin
          grant_nxt = 1'b1;
          busy_nxt  = 1'b1;
        end else if (tx_done) begin
          busy_nxt = 1'b0;
        end
      end
      ST_DRAIN: begin
        // tx_done is checked first so a frame ending on the timeout cycle
        // is never aborted.
        if (tx_done) begin
          busy_nxt = 1'b0;
          nxt      = fault_target(ftype);
        end else if (drain_cnt == DRAIN_LAST) begin
          abort_nxt = 1'b1;
          busy_nxt  = 1'b0;
          nxt       = fault_target(ftype);
        end
      end
      ST_F_LOCAL: begin
        if (ftype == FT_REM) begin
          nxt = ST_F_REMOTE;
        end else if (ftype == FT_NONE) begin
          nxt = ST_RECOVER;
        end
      end
      ST_F_REMOTE: begin
        if (ftype == FT_LOC) begin
          nxt = ST_F_LOCAL;
        end else if (ftype == FT_NONE) begin
          nxt = ST_RECOVER;
        end
      end
      ST_RECOVER: begin
        if (ftype != FT_NONE) begin
          nxt = fault_target(ftype);
        end else if (clear_cnt == CLEAR_LAST) begin
          nxt = ST_NORMAL;
        end
      end
      default: begin
        nxt      = ST_NORMAL;
        busy_nxt = 1'b0;
      end
    endcase
  end

  // State, timers and registered outputs. Outputs are decoded from the
  // next state so they line up with `state` in the same cycle.
  always_ff @(posedge rxclk_2x or negedge reset) begin
    if (!reset) begin
      st        <= ST_NORMAL;
      busy      <= 1'b0;
      drain_cnt <= '0;
      clear_cnt <= '0;
      tx_grant  <= 1'b0;
      tx_abort  <= 1'b0;
      send_idle <= 1'b0;
      send_rf   <= 1'b0;
      link_ok   <= 1'b1;
    end else begin
      st        <= nxt;
      busy      <= busy_nxt;
      tx_grant  <= grant_nxt;
      tx_abort  <= abort_nxt;
      // Timers run only while staying in their state; any entry starts at 0.
      drain_cnt <= ((st == ST_DRAIN) && (nxt == ST_DRAIN)) ? drain_cnt + 1'b1 : '0;
      clear_cnt <= ((st == ST_RECOVER) && (nxt == ST_RECOVER)) ? clear_cnt + 1'b1 : '0;
      send_rf   <= (nxt == ST_F_LOCAL);
      send_idle <= (nxt == ST_F_REMOTE) || (nxt == ST_RECOVER);
      link_ok   <= (nxt == ST_NORMAL);
    end
  end

  // An episode is an entry into a fault state from any other state.
  assign local_inc  = (nxt == ST_F_LOCAL) && (st != ST_F_LOCAL);
  assign remote_inc = (nxt == ST_F_REMOTE) && (st != ST_F_REMOTE);

  tx_fault_resp_ctrl_sat_counter #(
    .W (CNT_W)
  ) u_local_cnt (
    .clk   (rxclk_2x),
    .rst_n (reset),
    .inc   (local_inc),
    .clr   (cnt_clr),
    .count (local_cnt)
  );

  tx_fault_resp_ctrl_sat_counter #(
    .W (CNT_W)
  ) u_remote_cnt (
    .clk   (rxclk_2x),
    .rst_n (reset),
    .inc   (remote_inc),
    .clr   (cnt_clr),
    .count (remote_cnt)
  );

endmodule

// File: tb/tb_tx_fault_resp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tx_fault_resp_ctrl
// Two controllers share every input: one with 16-bit statistics, one with
// 2-bit statistics. Directed scenarios check fixed expectations; a random
// phase compares both instances against a behavioural model each cycle.
// ---------------------------------------------------------------------------
module tb_tx_fault_resp_ctrl;

  localparam int CLR_T = 128;
  localparam int DRN_T = 16;

  logic        clk;
  logic        reset;
  logic [1:0]  link_fault;
  logic        fault_resp_en;
  logic        tx_req;
  logic        tx_done;
  logic        cnt_clr;

  logic        a_grant, a_abort, a_idle, a_rf, a_ok;
  logic [2:0]  a_st;
  logic [15:0] a_lcnt, a_rcnt;
  logic        b_grant, b_abort, b_idle, b_rf, b_ok;
  logic [2:0]  b_st;
  logic [1:0]  b_lcnt, b_rcnt;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int m_mode;   // 0 normal, 1 drain, 2 local, 3 remote, 4 recover
  bit m_open;   // frame granted and not yet finished
  int m_wait;   // cycles spent draining
  int m_quiet;  // fault-free cycles spent recovering
  int m_loc, m_rem;
  bit e_grant, e_abort;

  tx_fault_resp_ctrl #(.CLEAR_CYCLES(CLR_T), .DRAIN_MAX(DRN_T), .CNT_W(16)) dut_a (
    .rxclk_2x(clk), .reset(reset), .link_fault(link_fault), .fault_resp_en(fault_resp_en),
    .tx_req(tx_req), .tx_done(tx_done), .cnt_clr(cnt_clr),
    .tx_grant(a_grant), .tx_abort(a_abort), .send_idle(a_idle), .send_rf(a_rf),
    .link_ok(a_ok), .state(a_st), .local_cnt(a_lcnt), .remote_cnt(a_rcnt));

  tx_fault_resp_ctrl #(.CLEAR_CYCLES(CLR_T), .DRAIN_MAX(DRN_T), .CNT_W(2)) dut_b (
    .rxclk_2x(clk), .reset(reset), .link_fault(link_fault), .fault_resp_en(fault_resp_en),
    .tx_req(tx_req), .tx_done(tx_done), .cnt_clr(cnt_clr),
    .tx_grant(b_grant), .tx_abort(b_abort), .send_idle(b_idle), .send_rf(b_rf),
    .link_ok(b_ok), .state(b_st), .local_cnt(b_lcnt), .remote_cnt(b_rcnt));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int satv(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_open = 0; m_wait = 0; m_quiet = 0;
    m_loc = 0; m_rem = 0; e_grant = 0; e_abort = 0;
  endtask

  // Applies the rules to the inputs presented in the current cycle.
  task automatic model_step();
    int kind, target, nmode;
    bit g, a;
    kind = 0;
    if (fault_resp_en) kind = link_fault[1] ? 1 : (link_fault[0] ? 2 : 0);
    target = (kind == 1) ? 2 : ((kind == 2) ? 3 : 0);
    nmode = m_mode; g = 0; a = 0;
    case (m_mode)
      0: begin
        if (kind != 0) begin
          if (m_open && !tx_done) nmode = 1;
          else begin nmode = target; m_open = 0; end
        end else if (tx_req && !m_open) begin
          g = 1; m_open = 1;
        end else if (tx_done) m_open = 0;
      end
      1: begin
        m_wait++;
        if (tx_done) begin m_open = 0; nmode = target; end
        else if (m_wait == DRN_T) begin a = 1; m_open = 0; nmode = target; end
      end
      2: if (kind == 2) nmode = 3; else if (kind == 0) nmode = 4;
      3: if (kind == 1) nmode = 2; else if (kind == 0) nmode = 4;
      default: begin
        if (kind != 0) nmode = target;
        else begin
          m_quiet++;
          if (m_quiet == CLR_T) nmode = 0;
        end
      end
    endcase
    if (nmode == 2 && m_mode != 2) m_loc++;
    if (nmode == 3 && m_mode != 3) m_rem++;
    if (cnt_clr) begin m_loc = 0; m_rem = 0; end
    if (nmode != 1) m_wait = 0;
    if (nmode != 4) m_quiet = 0;
    m_mode = nmode; e_grant = g; e_abort = a;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_normal(input string tag);
    int n;
    n = 0;
    while (a_ok !== 1'b1 && n < 400) begin tick(); n++; end
    total++;
    if (a_ok !== 1'b1) begin
      bad++;
      $display("FAIL %s: link_ok=%0b after %0d cycles, required 1", tag, a_ok, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; link_fault = 2'b00; fault_resp_en = 1'b1;
    tx_req = 1'b0; tx_done = 1'b0; cnt_clr = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    total++; if ({a_grant, a_abort, a_idle, a_rf, a_ok} !== 5'b00001) begin
      bad++; $display("FAIL reset_ctrl: got %b required 00001", {a_grant, a_abort, a_idle, a_rf, a_ok}); end
    total++; if (a_st !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d required 0", a_st); end
    total++; if (a_lcnt !== 16'd0 || a_rcnt !== 16'd0 || b_lcnt !== 2'd0 || b_rcnt !== 2'd0) begin
      bad++; $display("FAIL reset_cnt: got %0d/%0d required 0/0", a_lcnt, a_rcnt); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_idle_grant();
    tx_req = 1'b1;
    tick();
    total++; if (a_grant !== 1'b1) begin bad++; $display("FAIL first_grant: got %0b required 1", a_grant); end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (a_grant !== 1'b0) begin bad++; $display("FAIL no_regrant: cycle %0d got %0b required 0", i, a_grant); end
    end
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    total++; if (a_grant !== 1'b0) begin bad++; $display("FAIL done_cycle_grant: got %0b required 0", a_grant); end
    tick();
    total++; if (a_grant !== 1'b1) begin bad++; $display("FAIL second_grant: got %0b required 1", a_grant); end
    tx_req = 1'b0;
    tx_done = 1'b1; tick(); tx_done = 1'b0;
  endtask

  task automatic test_mid_frame_local();
    int aborts;
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    tx_req = 1'b1; tick(); tx_req = 1'b0;
    total++; if (a_grant !== 1'b1) begin bad++; $display("FAIL mf_grant: got %0b required 1", a_grant); end
    aborts = 0;
    for (int c = 1; c <= 23; c++) begin
      link_fault = (c >= 5) ? 2'b10 : 2'b00;
      tx_done = (c == 20);
      total++;
      if ((c <= 5 && a_st !== 3'd0) || (c >= 6 && c <= 20 && a_st !== 3'd1) ||
          (c >= 21 && (a_st !== 3'd2 || a_rf !== 1'b1))) begin
        bad++; $display("FAIL mf_state: cycle %0d state=%0d rf=%0b", c, a_st, a_rf);
      end
      if (a_abort) aborts++;
      tick();
    end
    tx_done = 1'b0;
    total++; if (aborts != 0) begin bad++; $display("FAIL mf_abort: got %0d pulses required 0", aborts); end
    total++; if (a_lcnt !== 16'd1 || b_lcnt !== 2'd1) begin
      bad++; $display("FAIL mf_local_cnt: got %0d required 1", a_lcnt); end
  endtask

  task automatic test_recover_debounce();
    link_fault = 2'b00; tick();
    for (int i = 0; i < 100; i++) begin
      total++; if (a_st !== 3'd4 || a_idle !== 1'b1) begin
        bad++; $display("FAIL rec_hold: cycle %0d state=%0d idle=%0b", i, a_st, a_idle); end
      tick();
    end
    link_fault = 2'b10; tick();
    total++; if (a_st !== 3'd2 || a_lcnt !== 16'd2) begin
      bad++; $display("FAIL rec_refault: state=%0d local_cnt=%0d required 2/2", a_st, a_lcnt); end
    link_fault = 2'b00; tick();
    for (int i = 0; i < 128; i++) begin
      total++; if (a_ok !== 1'b0 || a_st !== 3'd4) begin
        bad++; $display("FAIL rec_debounce: cycle %0d link_ok=%0b state=%0d", i, a_ok, a_st); end
      tick();
    end
    total++; if (a_ok !== 1'b1 || a_st !== 3'd0 || a_idle !== 1'b0) begin
      bad++; $display("FAIL rec_resume: link_ok=%0b state=%0d idle=%0b", a_ok, a_st, a_idle); end
  endtask

  task automatic test_drain_timeout();
    int aborts;
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    tx_req = 1'b1; tick(); tx_req = 1'b0;
    link_fault = 2'b01; tick();
    for (int i = 1; i <= 16; i++) begin
      total++; if (a_st !== 3'd1 || a_abort !== 1'b0 || a_ok !== 1'b0) begin
        bad++; $display("FAIL drain_wait: cycle %0d state=%0d abort=%0b", i, a_st, a_abort); end
      tick();
    end
    total++; if (a_abort !== 1'b1 || a_st !== 3'd3 || a_idle !== 1'b1) begin
      bad++; $display("FAIL drain_abort: abort=%0b state=%0d idle=%0b required 1/3/1", a_abort, a_st, a_idle); end
    total++; if (a_rcnt !== 16'd1) begin bad++; $display("FAIL drain_remote_cnt: got %0d required 1", a_rcnt); end
    aborts = 0;
    for (int i = 0; i < 5; i++) begin tick(); if (a_abort) aborts++; end
    total++; if (aborts != 0) begin bad++; $display("FAIL drain_single_abort: extra pulses %0d", aborts); end
    link_fault = 2'b00;
    wait_normal("drain_recover");
  endtask

  task automatic test_toggle();
    bit both;
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    both = 0;
    for (int s = 0; s < 10; s++) begin
      link_fault = (s % 2 == 0) ? 2'b10 : 2'b01;
      for (int k = 0; k < 3; k++) begin
        tick();
        if (a_rf && a_idle) both = 1;
        total++; if (a_rf !== (s % 2 == 0) || a_idle !== (s % 2 == 1)) begin
          bad++; $display("FAIL toggle_follow: seg %0d rf=%0b idle=%0b", s, a_rf, a_idle); end
      end
    end
    total++; if (both) begin bad++; $display("FAIL toggle_exclusive: rf and idle both 1"); end
    total++; if (32'(a_lcnt) + 32'(a_rcnt) != 10 || a_lcnt !== 16'd5) begin
      bad++; $display("FAIL toggle_cnt: local=%0d remote=%0d required 5/5", a_lcnt, a_rcnt); end
    total++; if (b_lcnt !== 2'd3 || b_rcnt !== 2'd3) begin
      bad++; $display("FAIL toggle_sat: local=%0d remote=%0d required 3/3", b_lcnt, b_rcnt); end
    link_fault = 2'b00;
    wait_normal("toggle_recover");
  endtask

  task automatic test_sat_clr();
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    for (int e = 0; e < 5; e++) begin
      link_fault = 2'b10; tick();
      link_fault = 2'b00; tick();
    end
    total++; if (b_lcnt !== 2'd3 || a_lcnt !== 16'd5) begin
      bad++; $display("FAIL sat_local: narrow=%0d wide=%0d required 3/5", b_lcnt, a_lcnt); end
    link_fault = 2'b10; cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    total++; if (a_st !== 3'd2 || a_lcnt !== 16'd0 || b_lcnt !== 2'd0) begin
      bad++; $display("FAIL clr_priority: state=%0d local=%0d/%0d required 2/0/0", a_st, a_lcnt, b_lcnt); end
    link_fault = 2'b00;
    wait_normal("sat_recover");
  endtask

  task automatic test_forced_ok();
    int n;
    link_fault = 2'b10; tick();
    fault_resp_en = 1'b0; tick();
    total++; if (a_st !== 3'd4 || a_idle !== 1'b1) begin
      bad++; $display("FAIL forced_recover: state=%0d idle=%0b required 4/1", a_st, a_idle); end
    n = 0;
    while (a_ok !== 1'b1 && n < 400) begin tick(); n++; end
    total++; if (n != 128) begin bad++; $display("FAIL forced_debounce: took %0d cycles required 128", n); end
    link_fault = 2'b00; fault_resp_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    tx_req = 1'b1; tick(); tx_req = 1'b0;
    link_fault = 2'b10; tick();
    total++; if (a_st !== 3'd1) begin bad++; $display("FAIL rm_pre: state=%0d required 1", a_st); end
    #2 reset = 1'b0;
    #1;
    total++; if (a_st !== 3'd0 || a_ok !== 1'b1 || a_lcnt !== 16'd0 || a_abort !== 1'b0) begin
      bad++; $display("FAIL rm_async: state=%0d ok=%0b cnt=%0d", a_st, a_ok, a_lcnt); end
    model_reset();
    link_fault = 2'b00;
    @(negedge clk); reset = 1'b1; @(negedge clk);
    tx_req = 1'b1; tick(); tx_req = 1'b0;
    total++; if (a_grant !== 1'b1) begin bad++; $display("FAIL rm_regrant: got %0b required 1", a_grant); end
    tx_done = 1'b1; tick(); tx_done = 1'b0;
  endtask

  task automatic test_random();
    logic [8:0] exp_ctrl;
    int rate;
    for (int blk = 0; blk < 6; blk++) begin
      rate = (blk % 2 == 1) ? 2 : 15;
      for (int i = 0; i < 500; i++) begin
        if ($urandom_range(0, 999) < rate) link_fault = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 999) < 3) fault_resp_en = ~fault_resp_en;
        tx_req  = ($urandom_range(0, 2) != 0);
        tx_done = ($urandom_range(0, 99) < 6);
        cnt_clr = ($urandom_range(0, 99) < 1);
        tick();
        exp_ctrl = {e_grant, e_abort, (m_mode == 3 || m_mode == 4), (m_mode == 2), (m_mode == 0), 3'(m_mode)};
        total++; if ({a_grant, a_abort, a_idle, a_rf, a_ok, a_st} !== exp_ctrl) begin
          bad++; $display("FAIL rnd_ctrl_a: cycle %0d got %b required %b", i, {a_grant, a_abort, a_idle, a_rf, a_ok, a_st}, exp_ctrl); end
        total++; if ({b_grant, b_abort, b_idle, b_rf, b_ok, b_st} !== exp_ctrl) begin
          bad++; $display("FAIL rnd_ctrl_b: cycle %0d got %b required %b", i, {b_grant, b_abort, b_idle, b_rf, b_ok, b_st}, exp_ctrl); end
        total++; if (a_lcnt !== 16'(satv(m_loc, 16)) || a_rcnt !== 16'(satv(m_rem, 16))) begin
          bad++; $display("FAIL rnd_cnt_a: cycle %0d got %0d/%0d required %0d/%0d", i, a_lcnt, a_rcnt, satv(m_loc, 16), satv(m_rem, 16)); end
        total++; if (b_lcnt !== 2'(satv(m_loc, 2)) || b_rcnt !== 2'(satv(m_rem, 2))) begin
          bad++; $display("FAIL rnd_cnt_b: cycle %0d got %0d/%0d required %0d/%0d", i, b_lcnt, b_rcnt, satv(m_loc, 2), satv(m_rem, 2)); end
      end
    end
    tx_req = 1'b0; tx_done = 1'b0; cnt_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_grant();
    test_mid_frame_local();
    test_recover_debounce();
    test_drain_timeout();
    test_toggle();
    test_sat_clr();
    test_forced_ok();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
